bcd_display_scanner: RTL and testbench

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_display_pkg.sv | 59 +++++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/bcd_display_scanner.sv | 144 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the multiplexed BCD display blocks.
package bcd_display_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    SLOT_SEC_ONES  = 3'd0,
    SLOT_SEC_TENS  = 3'd1,
    SLOT_MIN_ONES  = 3'd2,
    SLOT_MIN_TENS  = 3'd3,
    SLOT_HOUR_ONES = 3'd4,
    SLOT_HOUR_TENS = 3'd5
  } slot_t;

  function automatic slot_t next_slot(input slot_t s);
    slot_t n;
    case (s)
      SLOT_SEC_ONES:  n = SLOT_SEC_TENS;
      SLOT_SEC_TENS:  n = SLOT_MIN_ONES;
      SLOT_MIN_ONES:  n = SLOT_MIN_TENS;
      SLOT_MIN_TENS:  n = SLOT_HOUR_ONES;
      SLOT_HOUR_ONES: n = SLOT_HOUR_TENS;
      default:        n = SLOT_SEC_ONES;
    endcase
    return n;
  endfunction

  // Active-low anode enable for a single slot
  function automatic logic [NUM_DIGITS-1:0] slot_anode(input slot_t s);
    logic [NUM_DIGITS-1:0] a;
    case (s)
      SLOT_SEC_ONES:  a = 6'b111110;
      SLOT_SEC_TENS:  a = 6'b111101;
      SLOT_MIN_ONES:  a = 6'b111011;
      SLOT_MIN_TENS:  a = 6'b110111;
      SLOT_HOUR_ONES: a = 6'b101111;
      SLOT_HOUR_TENS: a = 6'b011111;
      default:        a = '1;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment decoder; values 10-15 render as a dash.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Six-digit multiplexed HH:MM:SS display scanner with per-frame input snapshot.
// Optional colon blink on the decimal points: define DISPLAY_COLON_BLINK_EN.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hour_ones,
  input  logic [3:0] hour_tens,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam logic [31:0] PRE_LAST  = 32'(SCAN_DIV - 1);
  localparam logic [31:0] PRE_BLANK = 32'(BLANK_CYCLES);

  logic [31:0] prescaler;
  slot_t       slot;

  bcd_t snap_sec_ones, snap_sec_tens, snap_min_ones;
  bcd_t snap_min_tens, snap_hour_ones, snap_hour_tens;

  logic       capture;
  logic       wrap;
  logic       blanked;
  bcd_t       eff_sec_ones, eff_sec_tens, eff_min_ones;
  bcd_t       eff_min_tens, eff_hour_ones, eff_hour_tens;
  bcd_t       cur_digit;
  logic [6:0] cur_seg;
  logic [5:0] an_next;

  always_comb begin
    capture = (prescaler == '0) && (slot == SLOT_SEC_ONES);
    wrap    = (prescaler == PRE_LAST);
    blanked = (prescaler < PRE_BLANK);
  end

  // In the capture cycle the register still holds the previous frame, so the
  // outputs are fed from the live inputs to keep slot 0 consistent with its frame.
  always_comb begin
    if (capture) begin
      eff_sec_ones  = sec_ones;
      eff_sec_tens  = sec_tens;
      eff_min_ones  = min_ones;
      eff_min_tens  = min_tens;
      eff_hour_ones = hour_ones;
      eff_hour_tens = hour_tens;
    end else begin
      eff_sec_ones  = snap_sec_ones;
      eff_sec_tens  = snap_sec_tens;
      eff_min_ones  = snap_min_ones;
      eff_min_tens  = snap_min_tens;
      eff_hour_ones = snap_hour_ones;
      eff_hour_tens = snap_hour_tens;
    end
  end

  always_comb begin
    cur_digit = eff_sec_ones;
    case (slot)
      SLOT_SEC_ONES:  cur_digit = eff_sec_ones;
      SLOT_SEC_TENS:  cur_digit = eff_sec_tens;
      SLOT_MIN_ONES:  cur_digit = eff_min_ones;
      SLOT_MIN_TENS:  cur_digit = eff_min_tens;
      SLOT_HOUR_ONES: cur_digit = eff_hour_ones;
      SLOT_HOUR_TENS: cur_digit = eff_hour_tens;
      default:        cur_digit = eff_sec_ones;
    endcase
  end

  bcd_to_7seg u_decoder (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Leading zero on the hour tens digit stays dark for the whole slot
  always_comb begin
    an_next = '1;
    if (!blanked && !((slot == SLOT_HOUR_TENS) && (eff_hour_tens == 4'd0)))
      an_next = slot_anode(slot);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler      <= '0;
      slot           <= SLOT_SEC_ONES;
      snap_sec_ones  <= '0;
      snap_sec_tens  <= '0;
      snap_min_ones  <= '0;
      snap_min_tens  <= '0;
      snap_hour_ones <= '0;
      snap_hour_tens <= '0;
      an             <= '1;
      seg            <= SEG_OFF;
      frame_done     <= 1'b0;
    end else begin
      if (wrap) begin
        prescaler <= '0;
        slot      <= next_slot(slot);
      end else begin
        prescaler <= prescaler + 32'd1;
      end
      if (capture) begin
        snap_sec_ones  <= sec_ones;
        snap_sec_tens  <= sec_tens;
        snap_min_ones  <= min_ones;
        snap_min_tens  <= min_tens;
        snap_hour_ones <= hour_ones;
        snap_hour_tens <= hour_tens;
      end
      an         <= an_next;
      seg        <= cur_seg;
      frame_done <= wrap && (slot == SLOT_HOUR_TENS);
    end
  end

`ifdef DISPLAY_COLON_BLINK_EN
  logic dp_next;

  always_comb begin
    dp_next = 1'b1;
    if (!blanked && !eff_sec_ones[0] &&
        ((slot == SLOT_MIN_ONES) || (slot == SLOT_HOUR_ONES)))
      dp_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dp <= 1'b1;
    else       dp <= dp_next;
  end
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner at SCAN_DIV=8, BLANK_CYCLES=2.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned ph = 0;

  logic [6:0] exp_seg [6];
  logic       blank5;
  logic       dp_on;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .hour_ones  (hour_ones),
    .hour_tens  (hour_tens),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s ph=%0d got=%b expected=%b", tag, ph, got, exp);
  endtask

  task automatic set_time(input logic [3:0] ht, input logic [3:0] ho, input logic [3:0] mt,
                          input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so);
    hour_tens = ht; hour_ones = ho; min_tens = mt;
    min_ones  = mo; sec_tens  = st; sec_ones = so;
  endtask

  task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5);
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2;
    exp_seg[3] = s3; exp_seg[4] = s4; exp_seg[5] = s5;
  endtask

  task automatic check_reset_outputs();
    chk("reset_an",  {1'b0, an}, 7'b0111111);
    chk("reset_seg", seg, 7'b1111111);
    chk("reset_dp",  {6'b0, dp}, 7'd1);
    chk("reset_fd",  {6'b0, frame_done}, 7'd0);
  endtask

  // ph counts output states since reset release: slot = (ph%48)/8, prescaler = ph%8
  task automatic run_cycles(input int n);
    int unsigned loc, sl, pre;
    logic        lit;
    logic [5:0]  one_hot, an_e;
    logic        dp_e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      loc = ph % 48;
      sl  = loc / 8;
      pre = loc % 8;
      lit = (pre >= 2) && !((sl == 5) && blank5);
      one_hot = 6'b000001;
      one_hot = one_hot << sl;
      an_e = lit ? ~one_hot : 6'b111111;
`ifdef DISPLAY_COLON_BLINK_EN
      dp_e = !(dp_on && (pre >= 2) && ((sl == 2) || (sl == 4)));
`else
      dp_e = 1'b1;
`endif
      chk("an",  {1'b0, an}, {1'b0, an_e});
      chk("seg", seg, exp_seg[sl]);
      chk("frame_done", {6'b0, frame_done}, {6'b0, (loc == 47)});
      chk("dp",  {6'b0, dp}, {6'b0, dp_e});
      ph++;
    end
  endtask

  initial begin
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    ph = 0;

    // 12:34:56, two frames; min_ones changes to 9 mid slot 2 of the second frame
    set_exp(7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    blank5 = 1'b0;
    dp_on  = 1'b1;
    run_cycles(48);
    run_cycles(20);
    min_ones = 4'd9;
    run_cycles(28);

    // 12:39:56 now visible
    exp_seg[2] = 7'b0010000;
    run_cycles(48);

    // 07:39:C5 -> leading-zero blank, dash, odd seconds
    set_time(4'd0, 4'd7, 4'd3, 4'd9, 4'hC, 4'd5);
    set_exp(7'b0010010, 7'b0111111, 7'b0010000, 7'b0110000, 7'b1111000, 7'b1000000);
    blank5 = 1'b1;
    dp_on  = 1'b0;
    run_cycles(48);

    // Reset mid slot 3, new time loaded while in reset
    run_cycles(28);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    ph = 0;
    set_exp(7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    blank5 = 1'b0;
    dp_on  = 1'b1;
    run_cycles(48);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
